// File: rtl/nnet_result_framer_pkg.sv
// Shared types and widths for the neural-net result framer.
// Imported by the interface, the header FIFO and the top.
package nnet_pkg;

    localparam int TUSER_W     = 128;
    localparam int NNET_DATA_W = 16;
    localparam int AXIS_W      = 32;
    localparam int SIZE_W_DEF  = 16;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/nnet_result_framer_if.sv
// Header, result and output streams of the framer.
// master = surrounding logic, slave = the framer.
interface nnet_result_framer_if;
    import nnet_pkg::*;

    logic [TUSER_W-1:0] hdr_tdata;
    logic               hdr_tvalid;
    logic               hdr_tready;

    logic [AXIS_W-1:0]  s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;

    logic [AXIS_W-1:0]  m_axis_tdata;
    logic               m_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [TUSER_W-1:0] m_axis_tuser;

    modport master (
        output hdr_tdata, hdr_tvalid,
        input  hdr_tready,
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tuser,
        output m_axis_tready
    );

    modport slave (
        input  hdr_tdata, hdr_tvalid,
        output hdr_tready,
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tuser,
        input  m_axis_tready
    );

endinterface

// File: rtl/nnet_result_framer_hdr_fifo.sv
// Saved-header FIFO: one tuser per input frame still in flight.
// Full/empty come straight from the occupancy register.
module nnet_hdr_fifo
    import nnet_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic [TUSER_W-1:0] din,
    input  logic               pop,
    output logic [TUSER_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [TUSER_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d;
    logic [DEPTH_LOG2-1:0] rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_q];

    // A push against a full FIFO is refused even if a pop frees a slot now
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + DEPTH_LOG2'(do_push);
        rd_d    = rd_q + DEPTH_LOG2'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/nnet_result_framer.sv
// Frames bare HLS results into tlast/tuser-tagged AXI packets.
// Define NNET_FRAMER_PACK_EN to pack two 16-bit results per word.
module nnet_result_framer
    import nnet_pkg::*;
#(
    parameter int HDR_DEPTH_LOG2 = 2,
    parameter int SIZE_W         = SIZE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [SIZE_W-1:0] size_out,
    nnet_result_framer_if.slave bus,
    output logic [31:0]       frame_count,
    output logic              err_zero_size
);

    state_e             state_q, state_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [SIZE_W-1:0]  cnt_q, cnt_d;
    logic [TUSER_W-1:0] user_q, user_d;
    logic [AXIS_W-1:0]  data_q, data_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic [31:0]        fcnt_q, fcnt_d;
    logic               err_q, err_d;
`ifdef NNET_FRAMER_PACK_EN
    logic [NNET_DATA_W-1:0] half_q, half_d;
    logic                   have_q, have_d;
`endif

    logic                   hdr_pop, hdr_full, hdr_empty;
    logic [TUSER_W-1:0]     hdr_dout;
    logic                   s_ready, s_fire, m_fire;
    logic                   is_last, load, last_loaded;
    logic [NNET_DATA_W-1:0] res;
    logic [AXIS_W-1:0]      word;
    logic                   unused_hi;

    nnet_hdr_fifo #(.DEPTH_LOG2(HDR_DEPTH_LOG2)) u_hdr_fifo (
        .clk   (clk),
        .rst   (reset),
        .clear (clear),
        .push  (bus.hdr_tvalid),
        .din   (bus.hdr_tdata),
        .pop   (hdr_pop),
        .dout  (hdr_dout),
        .full  (hdr_full),
        .empty (hdr_empty)
    );

    assign res       = bus.s_axis_tdata[NNET_DATA_W-1:0];
    assign unused_hi = ^bus.s_axis_tdata[AXIS_W-1:NNET_DATA_W];

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        user_d  = user_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        err_d   = err_q;
        hdr_pop = 1'b0;

        last_loaded = valid_q && last_q;
        s_ready = (state_q == RUN) && (!valid_q || bus.m_axis_tready)
                  && !last_loaded;
        s_fire  = s_ready && bus.s_axis_tvalid;
        m_fire  = valid_q && bus.m_axis_tready;
        is_last = (cnt_q == size_q - SIZE_W'(1));

`ifdef NNET_FRAMER_PACK_EN
        half_d = half_q;
        have_d = have_q;
        // The first half of a pair waits here until its partner arrives
        load   = s_fire && (is_last || have_q);
        word   = have_q ? {half_q, res} : {res, 16'h0000};
        if (s_fire && !load) begin
            half_d = res;
            have_d = 1'b1;
        end
        if (load) have_d = 1'b0;
`else
        load = s_fire;
        word = {16'h0000, res};
`endif

        unique case (state_q)
            IDLE: begin
                if (!hdr_empty) begin
                    if (size_out != '0) begin
                        state_d = RUN;
                        hdr_pop = 1'b1;
                        user_d  = hdr_dout;
                        size_d  = size_out;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (m_fire && last_q) begin
                    state_d = IDLE;
                    fcnt_d  = fcnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (s_fire) cnt_d = cnt_q + SIZE_W'(1);

        if (load) begin
            data_d  = word;
            last_d  = is_last;
            valid_d = 1'b1;
        end else if (m_fire) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= IDLE;
            size_q  <= '0;
            cnt_q   <= '0;
            user_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
`ifdef NNET_FRAMER_PACK_EN
            half_q  <= '0;
            have_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            user_q  <= user_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
`ifdef NNET_FRAMER_PACK_EN
            half_q  <= half_d;
            have_q  <= have_d;
`endif
        end
    end

    assign bus.hdr_tready    = !hdr_full;
    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tdata  = data_q;
    assign bus.m_axis_tlast  = last_q;
    assign bus.m_axis_tvalid = valid_q;
    assign bus.m_axis_tuser  = user_q;
    assign frame_count       = fcnt_q;
    assign err_zero_size     = err_q;

endmodule

// File: tb/tb_nnet_result_framer.sv
// Self-checking bench for nnet_result_framer: vector table,
// hand-written corner sequences and randomized frames vs. a queue model.
module tb_nnet_result_framer;
    import nnet_pkg::*;

    typedef logic [160:0] word_t;
    typedef struct {
        int sz;
        int nfr;
        int mode;
        int exp_fc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] size_out;
    logic [31:0] frame_count;
    logic        err_zero_size;

    nnet_result_framer_if bus ();

    nnet_result_framer #(.HDR_DEPTH_LOG2(2), .SIZE_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .size_out      (size_out),
        .bus           (bus.slave),
        .frame_count   (frame_count),
        .err_zero_size (err_zero_size)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int s_cnt = 0;
    int rdy_mode = 0;
    int vld_gap = 0;
    logic [31:0]  src_q[$];
    logic [127:0] hq[$];
    word_t        got_q[$];
    word_t        exp_q[$];
    int           fire_cyc[$];
    logic         stall_prev = 1'b0;
    word_t        held;

`ifdef NNET_FRAMER_PACK_EN
    localparam bit PACK = 1'b1;
`else
    localparam bit PACK = 1'b0;
`endif

    task automatic chk(string name, logic [191:0] got, logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic drive();
        bus.s_axis_tvalid = (src_q.size() > 0)
                            && ($urandom_range(0, 99) >= vld_gap);
        bus.s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : 32'h0;
        bus.hdr_tvalid    = (hq.size() > 0);
        bus.hdr_tdata     = (hq.size() > 0) ? hq[0] : 128'h0;
        case (rdy_mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = cyc[0];
            default: bus.m_axis_tready = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    task automatic cycle();
        word_t cur;
        bit    s_f, h_f;
        @(negedge clk);
        cur = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
        if (stall_prev) begin
            chk("stall_valid", bus.m_axis_tvalid, 1);
            chk("stall_hold", cur, held);
        end
        stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
        held = cur;
        s_f = bus.s_axis_tvalid && bus.s_axis_tready;
        h_f = bus.hdr_tvalid && bus.hdr_tready;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            got_q.push_back(cur);
            fire_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_f) begin
            void'(src_q.pop_front());
            s_cnt++;
        end
        if (h_f) void'(hq.pop_front());
        drive();
    endtask

    // Reference model: one frame = header + sz results -> expected words
    task automatic add_frame(input logic [127:0] h, input int sz,
                             input bit rnd, input int base);
        logic [15:0] r[$];
        for (int i = 0; i < sz; i++) begin
            r.push_back(rnd ? 16'($urandom) : 16'(base + i + 1));
            src_q.push_back({16'($urandom), r[i]});
        end
        hq.push_back(h);
        if (PACK) begin
            for (int i = 0; i < sz; i += 2) begin
                if (i + 1 < sz)
                    exp_q.push_back({h, (i + 1 == sz - 1), r[i], r[i+1]});
                else
                    exp_q.push_back({h, 1'b1, r[i], 16'h0000});
            end
        end else begin
            for (int i = 0; i < sz; i++)
                exp_q.push_back({h, (i == sz - 1), 16'h0000, r[i]});
        end
    endtask

    task automatic compare_all(input int fc);
        int n, k;
        n = exp_q.size();
        k = 0;
        while (got_q.size() < n && k < 2000) begin
            cycle();
            k++;
        end
        repeat (4) cycle();
        chk("word_count", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("word%0d", i), got_q[i], exp_q[i]);
        chk("frame_count", frame_count, fc);
    endtask

    task automatic flush_bench();
        src_q.delete();
        hq.delete();
        exp_q.delete();
        got_q.delete();
        fire_cyc.delete();
        s_cnt = 0;
        stall_prev = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        src_q.delete();
        hq.delete();
        drive();
        cycle();
        clear = 1'b0;
        flush_bench();
    endtask

    vec_t tbl[5];
    logic [127:0] h;
    int gap_exp, in_exp, wpf, sz, nf;

    initial begin
        tbl[0] = '{sz: 4, nfr: 1, mode: 0, exp_fc: 1};
        tbl[1] = '{sz: 6, nfr: 1, mode: 1, exp_fc: 1};
        tbl[2] = '{sz: 1, nfr: 3, mode: 2, exp_fc: 3};
        tbl[3] = '{sz: 5, nfr: 5, mode: 2, exp_fc: 5};
        tbl[4] = '{sz: 2, nfr: 4, mode: 1, exp_fc: 4};

        reset = 1'b1;
        clear = 1'b0;
        size_out = 16'd0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = 32'h0;
        bus.hdr_tvalid = 1'b0;
        bus.hdr_tdata = 128'h0;
        bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_tlast", bus.m_axis_tlast, 0);
        chk("rst_tdata", bus.m_axis_tdata, 0);
        chk("rst_tuser", bus.m_axis_tuser, 0);
        chk("rst_s_tready", bus.s_axis_tready, 0);
        chk("rst_hdr_tready", bus.hdr_tready, 1);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err", err_zero_size, 0);
        @(posedge clk);
        #1;

        // Vector table
        for (int e = 0; e < 5; e++) begin
            do_clear();
            size_out = 16'(tbl[e].sz);
            rdy_mode = tbl[e].mode;
            vld_gap = 0;
            for (int f = 0; f < tbl[e].nfr; f++) begin
                h = (e == 0) ? {16{8'hA5}} : {4{32'(e * 256 + f)}};
                add_frame(h, tbl[e].sz, 1'b0, f * 16);
            end
            drive();
            compare_all(tbl[e].exp_fc);
        end

        // Back-to-back frames: throughput and inter-frame bubble
        do_clear();
        size_out = 16'd4;
        rdy_mode = 0;
        add_frame({8{16'h0F0F}}, 4, 1'b1, 0);
        add_frame({8{16'hF0F0}}, 4, 1'b1, 0);
        drive();
        compare_all(2);
        wpf = PACK ? 2 : 4;
        in_exp = PACK ? 2 : 3;
        gap_exp = PACK ? 4 : 3;
        if (fire_cyc.size() >= 2 * wpf) begin
            chk("in_frame_span", fire_cyc[wpf-1] - fire_cyc[0], in_exp);
            chk("frame_gap", fire_cyc[wpf] - fire_cyc[wpf-1], gap_exp);
        end else begin
            chk("gap_words", fire_cyc.size(), 2 * wpf);
        end

        // size_out change mid-frame only affects the next frame
        do_clear();
        size_out = 16'd4;
        rdy_mode = 0;
        add_frame({4{32'h1234_5678}}, 4, 1'b1, 0);
        add_frame({4{32'h9ABC_DEF0}}, 2, 1'b1, 0);
        drive();
        for (int k = 0; k < 50 && s_cnt < 2; k++) cycle();
        chk("size_chg_reached", s_cnt, 2);
        size_out = 16'd2;
        compare_all(2);

        // Zero size: sticky error, headers held, FIFO fills
        do_clear();
        size_out = 16'd0;
        for (int f = 0; f < 4; f++)
            add_frame({4{32'(f + 32'hC0)}}, 3, 1'b1, 0);
        drive();
        repeat (10) cycle();
        chk("zero_err", err_zero_size, 1);
        chk("zero_s_tready", bus.s_axis_tready, 0);
        chk("zero_no_out", got_q.size(), 0);
        chk("zero_hdr_full", bus.hdr_tready, 0);
        size_out = 16'd3;
        compare_all(4);
        chk("zero_err_sticky", err_zero_size, 1);

        // Clear in the middle of a frame
        do_clear();
        size_out = 16'd4;
        rdy_mode = 0;
        add_frame({4{32'hDEAD_0001}}, 4, 1'b1, 0);
        add_frame({4{32'hDEAD_0002}}, 4, 1'b1, 0);
        drive();
        for (int k = 0; k < 50 && got_q.size() < 1; k++) cycle();
        chk("mid_started", got_q.size() > 0, 1);
        do_clear();
        @(negedge clk);
        chk("clr_tvalid", bus.m_axis_tvalid, 0);
        chk("clr_frame_count", frame_count, 0);
        chk("clr_hdr_tready", bus.hdr_tready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) src_q.push_back(32'(i + 7));
        drive();
        repeat (6) cycle();
        chk("clr_fifo_empty", got_q.size(), 0);
        chk("clr_no_accept", bus.s_axis_tready, 0);
        flush_bench();
        add_frame({4{32'hBEEF_0003}}, 4, 1'b1, 0);
        drive();
        compare_all(1);

`ifdef NNET_FRAMER_PACK_EN
        do_clear();
        size_out = 16'd3;
        rdy_mode = 0;
        hq.push_back({8{16'h5A5A}});
        src_q.push_back(32'h0000_1111);
        src_q.push_back(32'h0000_2222);
        src_q.push_back(32'h0000_3333);
        drive();
        for (int k = 0; k < 50 && got_q.size() < 2; k++) cycle();
        chk("pack_words", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("pack_w0", got_q[0], {{8{16'h5A5A}}, 1'b0, 32'h1111_2222});
            chk("pack_w1", got_q[1], {{8{16'h5A5A}}, 1'b1, 32'h3333_0000});
        end
`endif

        // Randomized frames against the queue model
        for (int it = 0; it < 4; it++) begin
            do_clear();
            sz = $urandom_range(1, 9);
            nf = $urandom_range(3, 7);
            size_out = 16'(sz);
            rdy_mode = 2;
            vld_gap = 30;
            for (int f = 0; f < nf; f++)
                add_frame({$urandom, $urandom, $urandom, $urandom},
                          sz, 1'b1, 0);
            drive();
            compare_all(nf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
